sha_mem_responder: RTL
======================

# sha_mem_responder

Memory-side responder for the SHA-256/bitcoin hash engines' word-addressed memory bus. Answers the engine's reads with one-cycle registered latency, absorbs its writes, and gives a host port for preloading message words and reading back results. A run FSM issues the engine's `start` pulse and waits for `done`. Protocol monitors flag out-of-range and uninitialised accesses.

## Interface
- `DEPTH`, 256: number of 32-bit words; legal addresses are 0..DEPTH-1.
- `ADDR_W`, 16: bus address width on both ports.
- `clk`, input, 1: single clock; the engine's `mem_clk` is the same net and is not an input here.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `host_we`, input, 1: host write strobe (IDLE only).
- `host_re`, input, 1: host read strobe (IDLE only).
- `host_addr`, input, ADDR_W: host word address.
- `host_wdata`, input, 32: host write data.
- `host_rdata`, output, 32: host read data.
- `host_rvalid`, output, 1: `host_rdata` valid this cycle.
- `host_err`, output, 1: one-cycle pulse when a host access is rejected.
- `arm`, input, 1: request an engine run.
- `start`, output, 1: one-cycle start pulse to the engine.
- `done`, input, 1: engine completion.
- `busy`, output, 1: high while a run is in progress.
- `mem_we`, input, 1: engine write enable.
- `mem_addr`, input, ADDR_W: engine word address.
- `mem_write_data`, input, 32: engine write data.
- `mem_read_data`, output, 32: read data to the engine.
- `wr_count`, output, 8: number of engine writes in the current or last run; saturates at 255.
- `err_oob`, output, 1: sticky; an engine access had an address ≥ DEPTH.
- `err_uninit`, output, 1: sticky; the engine read a word not written since reset.
- `err_bus`, output, 1: sticky; an engine write occurred while not BUSY.

## Operation
- **FSM states:** IDLE, START, BUSY.
  - IDLE → START on `arm`.
  - START → BUSY unconditionally; `start` = 1 only in START.
  - BUSY → IDLE on `done`.
  - `arm` outside IDLE is ignored. `done` outside BUSY is ignored.
- **Clearing on arm:** entering START clears `wr_count`, `err_oob`, `err_uninit` and `err_bus`.
- **Bus ownership in IDLE:**
  - Host owns the array.
  - `host_we` writes the word; `host_re` reads it.
  - `host_we` and `host_re` together: the write is performed and the read is ignored.
  - An engine `mem_we` in IDLE is discarded and sets `err_bus`. Engine reads in IDLE are served but unmonitored.
- **Bus ownership in START/BUSY:**
  - The engine owns the array.
  - Any host strobe is discarded, with `host_err` = 1 the next cycle.
- **Engine reads:** every cycle that `mem_we` = 0, `mem_addr` is read.
  - `mem_read_data` holds that word in the next cycle.
  - Address ≥ DEPTH: return POISON (32'hDEAD_BEEF) and, in BUSY, set `err_oob`.
  - In-range word whose valid bit is clear: return the array contents and, in BUSY, set `err_uninit`.
- **Engine writes:** `mem_we` = 1 in BUSY.
  - In range: write the word, set its valid bit, increment `wr_count` (saturating).
  - Out of range: discard the write and set `err_oob`.
- **Valid bits:** one per word, set by any accepted write from either port, cleared only by reset.
- **Address decode:** addresses are compared at the full ADDR_W width; there is no wrap or aliasing.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - `start`, `busy`, `host_rvalid`, `host_err` = 0.
  - `host_rdata` = 0, `mem_read_data` = 0.
  - `wr_count` = 0; all error flags = 0; all valid bits = 0.
  - Array data is not reset.
- **Read latency:** engine and host reads both take 1 cycle; the address is presented in cycle N and data is valid in cycle N+1. `host_rvalid` is high exactly in N+1.
- **Write-then-read:** a write in cycle N followed by a read of the same address in cycle N+1 returns the new data in N+2.
- **Run timing:** `arm` sampled in cycle N → `start` = 1 in N+1, `busy` = 1 from N+1. `done` sampled in cycle M → `busy` = 0 from M+1, and `arm` is accepted again from M+1.
- **Reset mid-run:** return to IDLE immediately, drop `start`/`busy`, clear counters, flags and valid bits; do not drive a `start` afterwards.

## Structure
- **Package `sha_mem_pkg`:**
  - `run_state_t` enum {IDLE, START, BUSY}.
  - POISON constant.
  - DEPTH_DEFAULT.
- **Sub-module `sha_mem_array`:** single-port synchronous RAM with registered read (`we`, `addr`, `wdata`, `rdata`). The top level muxes host/engine onto it by FSM state, and holds the valid bits, monitors and counter.

## Test plan
- **Host load/readback:** write 32'h0123_4567 to address 5, read address 5 → `host_rdata` = 32'h0123_4567 with `host_rvalid` one cycle after `host_re`.
- **Engine run:** `arm` → `start` pulse one cycle later. Engine reads 0..15 (preloaded), writes 16 words to 16..31, asserts `done` → `wr_count` = 16, `busy` falls the cycle after `done`, all error flags 0.
- **Out-of-range:** engine reads address 300 during BUSY with DEPTH = 256 → `mem_read_data` = 32'hDEAD_BEEF, `err_oob` = 1. A write to 300 leaves the array unchanged.
- **Uninitialised read:** read address 40, never written, during BUSY → `err_uninit` = 1. A second `arm` clears it.
- **Host during run:** `host_we` in BUSY → `host_err` pulse, word unchanged. Engine `mem_we` in IDLE → `err_bus` = 1.
- **Reset mid-run:** drop `reset_n` while BUSY → IDLE, `busy` = 0, `wr_count` = 0. Releasing reset produces no `start`.

Source files
------------

// File: rtl/sha_mem_pkg.sv
// Shared types and constants for the SHA engine memory responder.
package sha_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } run_state_t;

    localparam logic [31:0] POISON        = 32'hDEAD_BEEF;
    localparam int          DEPTH_DEFAULT = 256;

endpackage

// File: rtl/sha_mem_array.sv
// Single-port word RAM with a registered, read-first read port.
module sha_mem_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Only the output register is reset; the storage itself keeps its contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sha_mem_responder.sv
// Memory-side responder for the SHA engine bus: host preload/readback,
// run sequencing, and protocol monitors on engine accesses.
module sha_mem_responder
    import sha_mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_we,
    input  logic              host_re,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic [31:0]       host_rdata,
    output logic              host_rvalid,
    output logic              host_err,
    input  logic              arm,
    output logic              start,
    input  logic              done,
    output logic              busy,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_write_data,
    output logic [31:0]       mem_read_data,
    output logic [7:0]        wr_count,
    output logic              err_oob,
    output logic              err_uninit,
    output logic              err_bus
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    run_state_t state, state_nxt;

    logic             host_own, host_in, eng_in, host_acc;
    logic             eng_rd_p0, arm_take, in_busy;
    logic             ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_wdata, ram_rdata;
    logic             host_vld_p1, host_err_p1, oob_p1;
    logic [DEPTH-1:0] valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign host_own  = (state == IDLE);
    assign in_busy   = (state == BUSY);
    assign arm_take  = host_own && arm;
    assign host_in   = (host_addr < DEPTH_A);
    assign eng_in    = (mem_addr < DEPTH_A);
    assign host_acc  = host_own && (host_we || host_re);
    assign eng_rd_p0 = !host_acc && !mem_we;

    // Host wins the array in IDLE; engine writes only land during BUSY.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = mem_addr[IDX_W-1:0];
        ram_wdata = mem_write_data;
        if (host_acc) begin
            ram_addr  = host_addr[IDX_W-1:0];
            ram_wdata = host_wdata;
            ram_we    = host_we && host_in;
        end else if (in_busy) begin
            ram_we    = mem_we && eng_in;
        end
    end

    sha_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .rdata   (ram_rdata)
    );

    // p0 -> p1: read qualifiers aligned with the registered array output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_vld_p1 <= 1'b0;
            host_err_p1 <= 1'b0;
            oob_p1      <= 1'b0;
        end else begin
            host_vld_p1 <= host_own && host_re && !host_we && host_in;
            host_err_p1 <= (host_we || host_re) && (!host_own || !host_in);
            oob_p1      <= eng_rd_p0 && !eng_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (ram_we) begin
            valid[ram_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count   <= 8'd0;
            err_oob    <= 1'b0;
            err_uninit <= 1'b0;
            err_bus    <= 1'b0;
        end else if (arm_take) begin
            wr_count   <= 8'd0;
            err_oob    <= 1'b0;
            err_uninit <= 1'b0;
            err_bus    <= 1'b0;
        end else begin
            if (in_busy && !eng_in) begin
                err_oob <= 1'b1;
            end
            if (in_busy && !mem_we && eng_in && !valid[mem_addr[IDX_W-1:0]]) begin
                err_uninit <= 1'b1;
            end
            if (mem_we && !in_busy) begin
                err_bus <= 1'b1;
            end
            if (in_busy && mem_we && eng_in) begin
                wr_count <= sat_inc8(wr_count);
            end
        end
    end

    assign start         = (state == START);
    assign busy          = (state != IDLE);
    assign host_rdata    = ram_rdata;
    assign host_rvalid   = host_vld_p1;
    assign host_err      = host_err_p1;
    assign mem_read_data = oob_p1 ? POISON : ram_rdata;

endmodule
